// File: rtl/wide_add_sequencer.sv
// Sequences a DATA_W*WORDS-bit addition through an external combinational DATA_W-bit adder,
// one slice per cycle, least-significant slice first, with the carry chained between slices.
module wide_add_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WORDS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W*WORDS-1:0]   op_a,
  input  logic [DATA_W*WORDS-1:0]   op_b,
  input  logic                      op_cin,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  output logic                      add_cin,
  input  logic [DATA_W-1:0]         add_sum,
  input  logic                      add_cout,
  input  logic                      add_overflow,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W*WORDS-1:0]   result,
  output logic                      carry_out,
  output logic                      overflow,
  output logic                      busy
);

  localparam int unsigned OpW  = DATA_W * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [OpW-1:0]    op_a_q, op_a_d;
  logic [OpW-1:0]    op_b_q, op_b_d;
  logic [OpW-1:0]    result_q, result_d;
  logic              op_cin_q, op_cin_d;
  logic              carry_q, carry_d;
  logic              carry_out_q, carry_out_d;
  logic              overflow_q, overflow_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] slice_a, slice_b;
  logic              run;

  assign run = (state_q == StRun);

  // Select the operand slices addressed by the current word index.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx_q == IdxW'(i)) begin
        slice_a = op_a_q[i*DATA_W +: DATA_W];
        slice_b = op_b_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (run) begin
      add_a   = slice_a;
      add_b   = slice_b;
      add_cin = (idx_q == '0) ? op_cin_q : carry_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    result_d    = result_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d   = op_a;
          op_b_d   = op_b;
          op_cin_d = op_cin;
          idx_d    = '0;
          result_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < WORDS; i++) begin
          if (idx_q == IdxW'(i)) begin
            result_d[i*DATA_W +: DATA_W] = add_sum;
          end
        end
        carry_d = add_cout;
        idx_d   = idx_q + IdxW'(1);
        // Only the most-significant slice's flags describe the wide add.
        if (idx_q == LastIdx) begin
          carry_out_d = add_cout;
          overflow_d  = add_overflow;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: directed cases plus randomized ops checked against a
// cycle-counting arithmetic model of the wide add.
module tb_wide_add_sequencer;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int OW = DW * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (WORDS=4)
  logic          in_valid = 1'b0, in_ready, op_cin = 1'b0;
  logic [OW-1:0] op_a = '0, op_b = '0, result;
  logic [DW-1:0] add_a, add_b, add_sum;
  logic          add_cin, add_cout, add_overflow;
  logic          out_valid, out_ready = 1'b0, carry_out, overflow, busy;

  wide_add_sequencer #(.DATA_W(DW), .WORDS(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_overflow(add_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .overflow(overflow), .busy(busy)
  );

  // Stand-in for adder_16bit
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);
  assign add_overflow = (add_a[DW-1] == add_b[DW-1]) && (add_sum[DW-1] != add_a[DW-1]);

  // Single-slice DUT (WORDS=1)
  logic          in_valid1 = 1'b0, in_ready1, op_cin1 = 1'b0;
  logic [DW-1:0] op_a1 = '0, op_b1 = '0, result1;
  logic [DW-1:0] add_a1, add_b1, add_sum1;
  logic          add_cin1, add_cout1, add_overflow1;
  logic          out_valid1, out_ready1 = 1'b1, carry_out1, overflow1, busy1;

  wide_add_sequencer #(.DATA_W(DW), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .op_cin(op_cin1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1), .add_overflow(add_overflow1),
    .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
    .carry_out(carry_out1), .overflow(overflow1), .busy(busy1)
  );

  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + 17'(add_cin1);
  assign add_overflow1 = (add_a1[DW-1] == add_b1[DW-1]) && (add_sum1[DW-1] != add_a1[DW-1]);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: an accepted op completes W cycles later with the plain wide sum.
  logic          m_busy = 1'b0, m_valid = 1'b0, m_cin = 1'b0, m_co = 1'b0, m_ov = 1'b0;
  int            m_age = 0;
  logic [OW-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [OW:0]   m_sum;

  assign m_sum = {1'b0, m_a} + {1'b0, m_b} + (OW+1)'(m_cin);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_age <= 0;
      m_res <= '0; m_co <= 1'b0; m_ov <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1; m_age <= 0; m_res <= '0;
        m_a <= op_a; m_b <= op_b; m_cin <= op_cin;
      end
    end else if (!m_valid) begin
      m_age <= m_age + 1;
      if (m_age == W - 1) begin
        m_valid <= 1'b1;
        m_res   <= m_sum[OW-1:0];
        m_co    <= m_sum[OW];
        m_ov    <= (m_a[OW-1] == m_b[OW-1]) && (m_sum[OW-1] != m_a[OW-1]);
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  int dut_done = 0;
  always @(posedge clk) if (!rst && out_valid && out_ready) dut_done <= dut_done + 1;

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin : cmp
    logic [79:0] mask, part;
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, m_busy);
    chk("in_ready", in_ready, !m_busy);
    if (m_busy && !m_valid) begin
      // Carry into slice k is the carry out of the low k slices' sum.
      mask = (80'd1 << (DW * m_age)) - 80'd1;
      part = (80'(m_a) & mask) + (80'(m_b) & mask) + 80'(m_cin);
      chk("add_a", add_a, 16'(m_a >> (DW * m_age)));
      chk("add_b", add_b, 16'(m_b >> (DW * m_age)));
      chk("add_cin", add_cin, (part >> (DW * m_age)) & 80'd1);
    end else begin
      chk("add_a_idle", add_a, 0);
      chk("add_cin_idle", add_cin, 0);
      chk("result", result, m_res);
      chk("carry_out", carry_out, m_co);
      chk("overflow", overflow, m_ov);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cin,
                       output int lat, output int cin_ones);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin tick(); t++; end
    if (t >= 20) chk("wait_in_ready", 0, 1);
    op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; op_cin = 1'(~cin);
    lat = 0; cin_ones = 0;
    while (!out_valid && lat < 20) begin
      if (add_cin) cin_ones++;
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin : wdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, ones;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", result, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_add_a", add_a, 0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);

    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, lat, ones);
    chk("t1_latency", lat, W);
    chk("t1_result", result, 64'h0000_0000_0001_0000);
    chk("t1_carry", carry_out, 0);
    chk("t1_ovf", overflow, 0);
    release_result();

    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, lat, ones);
    chk("t2_result", result, 0);
    chk("t2_carry", carry_out, 1);
    chk("t2_ovf", overflow, 0);
    chk("t2_cin_ones", ones, 4);
    release_result();

    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat, ones);
    chk("t3_result", result, 64'h8000_0000_0000_0000);
    chk("t3_ovf", overflow, 1);
    chk("t3_carry", carry_out, 0);
    release_result();

    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, lat, ones);
    chk("t4_result", result, 0);
    chk("t4_ovf", overflow, 1);
    chk("t4_carry", carry_out, 1);
    release_result();

    // Backpressure with new operands offered while DONE
    do_op(64'h10, 64'h20, 1'b0, lat, ones);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
      tick();
      chk("bp_result", result, 64'h30);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    release_result();
    chk("bp_after_in_ready", in_ready, 1);
    chk("bp_after_out_valid", out_valid, 0);
    chk("bp_after_result", result, 64'h30);

    // Reset in the middle of RUN
    op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h1; op_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    do_op(64'h1, 64'h2, 1'b0, lat, ones);
    chk("rst_next_result", result, 64'h3);
    release_result();

    // WORDS=1 instance
    op_a1 = 16'h7FFF; op_b1 = 16'h0001; op_cin1 = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    chk("w1_busy", busy1, 1);
    chk("w1_not_yet", out_valid1, 0);
    tick();
    chk("w1_out_valid", out_valid1, 1);
    chk("w1_result", result1, 16'h8000);
    chk("w1_ovf", overflow1, 1);
    chk("w1_carry", carry_out1, 0);
    tick();
    chk("w1_in_ready", in_ready1, 1);

    // Randomized back-to-back operations
    for (int n = 0; n < 200; n++) begin
      logic r;
      int   t;
      case ($urandom % 4)
        0: op_a = '1;
        1: op_a = 64'h7FFF_FFFF_FFFF_FFFF;
        default: op_a = {$urandom, $urandom};
      endcase
      op_b = {$urandom, $urandom};
      op_cin = 1'($urandom);
      in_valid = 1'b1;
      t = 0;
      do begin
        r = in_ready;
        tick();
        out_ready = ($urandom_range(0, 3) != 0);
        t++;
      end while (!r && t < 50);
      if (t >= 50) chk("rand_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (W + 4) tick();
    chk("ops_completed", dut_done, 206);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Upstream controller for the combinational adder_16bit.
- Performs a WORDS×16-bit addition by driving adder_16bit once per cycle, least-significant word first, and chaining the adder's cout into the next word's cin.
- Accepts operands over a valid/ready handshake and holds the wide result until it is consumed.
- Lets the existing 16-bit datapath serve 32/64-bit adds without widening the adder.

Parameters:
- DATA_W, 16, width of one adder slice; must match adder_16bit.
- WORDS, 4, number of slices per operation (≥1); operand width is DATA_W*WORDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  sequencer can accept operands.
- op_a  in  DATA_W*WORDS  operand A.
- op_b  in  DATA_W*WORDS  operand B.
- op_cin  in  1  carry-in to the least-significant slice.
- add_a  out  DATA_W  to adder_16bit a.
- add_b  out  DATA_W  to adder_16bit b.
- add_cin  out  1  to adder_16bit cin.
- add_sum  in  DATA_W  from adder_16bit sum; combinational, same cycle.
- add_cout  in  1  from adder_16bit cout.
- add_overflow  in  1  from adder_16bit overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_W*WORDS  wide sum.
- carry_out  out  1  carry out of the most-significant slice.
- overflow  out  1  signed overflow of the wide add; taken from the MS slice's add_overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; idx, carry_reg, result, carry_out, overflow, out_valid clear to 0.
  - in_ready=1 once rst deasserts.
  - add_a/add_b/add_cin=0.
- FSM states:
  - IDLE: in_ready=1, busy=0, add_* driven 0. On in_valid&&in_ready at an edge: latch op_a, op_b, op_cin; idx←0; clear result; go to RUN.
  - RUN: in_ready=0, busy=1.
    - Combinational drive: add_a=op_a_q[idx*DATA_W +: DATA_W], add_b likewise from op_b_q, add_cin=(idx==0)?op_cin_q:carry_reg.
    - Each edge: result slice idx←add_sum; carry_reg←add_cout; idx←idx+1.
    - At idx==WORDS-1: also carry_out←add_cout, overflow←add_overflow; go to DONE.
    - The overflow of lower slices is ignored.
  - DONE: out_valid=1, busy=1, in_ready=0, add_* driven 0; result/carry_out/overflow stable. On out_valid&&out_ready at an edge: out_valid←0, go to IDLE.
- Latency: out_valid rises exactly WORDS cycles after the accepting edge; throughput is one op per WORDS+2 cycles minimum.
- in_valid in RUN/DONE is ignored; no queuing; op_* may change freely after acceptance.
- out_ready held low: DONE persists indefinitely with outputs frozen.
- result, carry_out and overflow keep their last values after leaving DONE until the next acceptance clears result.
- The idx counter is $clog2(WORDS) bits, minimum 1. With WORDS=1, RUN lasts one cycle; carry_out and overflow come from that slice.
- rst asserted in RUN or DONE aborts immediately: state returns to IDLE with outputs cleared, and the partial result is discarded.
- Arithmetic is modulo 2^(DATA_W*WORDS): result == op_a+op_b+op_cin, and carry_out is bit DATA_W*WORDS of that sum.

Test Plan:
- WORDS=4: op_a=0x0000_0000_0000_FFFF, op_b=0x1, cin=0 -> result=0x0000_0000_0001_0000, carry_out=0, overflow=0; out_valid exactly 4 cycles after acceptance.
- op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=0, cin=1 -> result=0, carry_out=1, overflow=0; add_cin observed as 1 on each of the 4 RUN cycles.
- op_a=0x7FFF_FFFF_FFFF_FFFF, op_b=1, cin=0 -> result=0x8000_0000_0000_0000, overflow=1, carry_out=0. Also 0x8000_0000_0000_0000+0x8000_0000_0000_0000 -> result=0, overflow=1, carry_out=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid with new operands -> result frozen, in_ready=0, new operands not accepted; after out_ready=1 for one edge -> IDLE, in_ready=1.
- Reset mid-RUN: assert rst after 2 RUN cycles of 0x1234_5678_9ABC_DEF0+0x1 -> immediately out_valid=0, result=0, busy=0, in_ready=1 after release; the next op 0x1+0x2 -> result=0x3.
- WORDS=1 build: 0x7FFF+0x0001 -> result=0x8000, overflow=1, out_valid 1 cycle after acceptance. Then 200 random back-to-back ops at WORDS=4 checked against a 64-bit behavioural sum, with zero mismatches.
